conv_sequencer: RTL and testbench

Control sequencer for the 128x32 streaming 1-D convolution datapath. It owns the x and f sample-buffer write ports during load and steps the 32-wide parallel read/MAC datapath through all N-M+1 output positions. It also drives the AXI-stream-style output handshake for y. It sits between the input stream ports and the memory/accumulator datapath and replaces the ad-hoc per-memory controllers with one explicit FSM.

---
 rtl/conv_sequencer.sv | 107 ++++++++++
 tb/tb_conv_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/conv_sequencer.sv
// conv_sequencer: load/issue/accumulate/output FSM for the N x M streaming 1-D convolution datapath.
// Optional output stall counter enabled by defining CONV_STALL_CNT_EN.
module conv_sequencer #(
   parameter int N    = 128,
   parameter int M    = 32,
   parameter int LOGN = 7,
   parameter int LOGM = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            s_valid_x,
   output logic            s_ready_x,
   output logic            wr_en_x,
   output logic [LOGN-1:0] wr_addr_x,
   input  logic            s_valid_f,
   output logic            s_ready_f,
   output logic            wr_en_f,
   output logic [LOGM-1:0] wr_addr_f,
   output logic [LOGN-1:0] rd_addr_x,
   output logic            clr_acc,
   output logic            en_acc,
   output logic            m_valid_y,
   input  logic            m_ready_y
`ifdef CONV_STALL_CNT_EN
   ,output logic [31:0]    stall_cnt
`endif
);
   typedef enum logic [2:0] {LOAD, ISSUE, MEM, ACC, OUT} state_t;
   state_t          r_state, w_next;
   logic [LOGN:0]   r_x_cnt;
   logic [LOGM:0]   r_f_cnt;
   logic [LOGN-1:0] r_k;
   logic            w_x_done, w_f_done, w_last;

   // a stream counts as done on the edge its last sample is accepted
   assign w_x_done  = (r_x_cnt == (LOGN+1)'(N)) | ((r_x_cnt == (LOGN+1)'(N-1)) & wr_en_x);
   assign w_f_done  = (r_f_cnt == (LOGM+1)'(M)) | ((r_f_cnt == (LOGM+1)'(M-1)) & wr_en_f);
   assign w_last    = r_k == LOGN'(N-M);
   assign wr_en_x   = s_valid_x & s_ready_x;
   assign wr_en_f   = s_valid_f & s_ready_f;
   assign wr_addr_x = r_x_cnt[LOGN-1:0];
   assign wr_addr_f = r_f_cnt[LOGM-1:0];
   assign rd_addr_x = (r_state == LOAD) ? '0 : r_k;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= LOAD;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      s_ready_x = 1'b0;
      s_ready_f = 1'b0;
      clr_acc   = 1'b0;
      en_acc    = 1'b0;
      m_valid_y = 1'b0;
      case (r_state)
         LOAD: begin
            s_ready_x = r_x_cnt < (LOGN+1)'(N);
            s_ready_f = r_f_cnt < (LOGM+1)'(M);
            if (w_x_done && w_f_done) w_next = ISSUE;
         end
         ISSUE: begin
            clr_acc = 1'b1;
            w_next  = MEM;
         end
         MEM: w_next = ACC;
         ACC: begin
            en_acc = 1'b1;
            w_next = OUT;
         end
         OUT: begin
            m_valid_y = 1'b1;
            if (m_ready_y) w_next = w_last ? LOAD : ISSUE;
         end
         default: w_next = LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_x_cnt <= '0;
         r_f_cnt <= '0;
         r_k     <= '0;
      end else begin
         if (wr_en_x) r_x_cnt <= r_x_cnt + 1'b1;
         if (wr_en_f) r_f_cnt <= r_f_cnt + 1'b1;
         if (r_state == LOAD) r_k <= '0;
         else if (r_state == OUT && m_ready_y) begin
            if (w_last) begin
               r_x_cnt <= '0;
               r_f_cnt <= '0;
               r_k     <= '0;
            end else r_k <= r_k + 1'b1;
         end
      end
   end

`ifdef CONV_STALL_CNT_EN
   logic [31:0] r_stall_cnt;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_stall_cnt <= '0;
      else if (r_state == OUT && !m_ready_y && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
   end
   assign stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_conv_sequencer.sv
// tb_conv_sequencer: directed checks of load addressing, issue timing, back-pressure, wrap and async reset.
module tb_conv_sequencer;
   localparam int N = 128;
   localparam int M = 32;
   logic clk = 0, reset = 0, s_valid_x = 0, s_valid_f = 0, m_ready_y = 1;
   logic s_ready_x, wr_en_x, s_ready_f, wr_en_f, clr_acc, en_acc, m_valid_y;
   logic [6:0] wr_addr_x, rd_addr_x;
   logic [4:0] wr_addr_f;
`ifdef CONV_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   conv_sequencer dut (
      .clk(clk), .reset(reset),
      .s_valid_x(s_valid_x), .s_ready_x(s_ready_x), .wr_en_x(wr_en_x), .wr_addr_x(wr_addr_x),
      .s_valid_f(s_valid_f), .s_ready_f(s_ready_f), .wr_en_f(wr_en_f), .wr_addr_f(wr_addr_f),
      .rd_addr_x(rd_addr_x), .clr_acc(clr_acc), .en_acc(en_acc),
      .m_valid_y(m_valid_y), .m_ready_y(m_ready_y)
`ifdef CONV_STALL_CNT_EN
      ,.stall_cnt(stall_cnt)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_rdy_x"}, s_ready_x, 1);
      check({tag, "_rdy_f"}, s_ready_f, 1);
      check({tag, "_wen_x"}, wr_en_x, 0);
      check({tag, "_wen_f"}, wr_en_f, 0);
      check({tag, "_vld"}, m_valid_y, 0);
      check({tag, "_clr"}, clr_acc, 0);
      check({tag, "_en"}, en_acc, 0);
      check({tag, "_rd"}, rd_addr_x, 0);
      check({tag, "_wa_x"}, wr_addr_x, 0);
      check({tag, "_wa_f"}, wr_addr_f, 0);
`ifdef CONV_STALL_CNT_EN
      check({tag, "_stall"}, stall_cnt, 0);
`endif
   endtask

   task automatic load_b2b;
      s_valid_x = 1;
      s_valid_f = 1;
      #1;
      for (int i = 0; i < N; i++) begin
         check("ld_wen_x", wr_en_x, 1);
         check("ld_addr_x", wr_addr_x, i);
         if (i < M) begin
            check("ld_wen_f", wr_en_f, 1);
            check("ld_addr_f", wr_addr_f, i);
         end else begin
            check("ld_rdy_f_low", s_ready_f, 0);
            check("ld_wen_f_low", wr_en_f, 0);
         end
         tick;
      end
   endtask

   task automatic outs(input int stall_k, input int abort_k);
      for (int k = 0; k <= N - M; k++) begin
         check("iss_clr", clr_acc, 1);
         check("iss_en", en_acc, 0);
         check("iss_rd", rd_addr_x, k);
         check("iss_vld", m_valid_y, 0);
         check("iss_rdy_x", s_ready_x, 0);
         check("iss_rdy_f", s_ready_f, 0);
         check("iss_wen_x", wr_en_x, 0);
         tick;
         check("mem_clr", clr_acc, 0);
         check("mem_en", en_acc, 0);
         check("mem_vld", m_valid_y, 0);
         tick;
         check("acc_en", en_acc, 1);
         check("acc_clr", clr_acc, 0);
         check("acc_vld", m_valid_y, 0);
         tick;
         check("out_vld", m_valid_y, 1);
         check("out_rd", rd_addr_x, k);
         check("out_en", en_acc, 0);
         if (k == abort_k) return;
         if (k == stall_k) begin
            m_ready_y = 0;
            for (int c = 0; c < 10; c++) begin
               check("bp_vld", m_valid_y, 1);
               check("bp_rd", rd_addr_x, k);
               check("bp_en", en_acc, 0);
               tick;
            end
            m_ready_y = 1;
`ifdef CONV_STALL_CNT_EN
            check("stall_cnt", stall_cnt, 10);
`endif
         end
         tick;
      end
      check("wrap_rdy_x", s_ready_x, 1);
      check("wrap_rdy_f", s_ready_f, 1);
      check("wrap_vld", m_valid_y, 0);
      check("wrap_rd", rd_addr_x, 0);
   endtask

   initial begin
      int ex, ef;
      #12;
      check_reset_vals("rst");
      @(negedge clk);
      reset = 1;
      tick;
      check_reset_vals("idle");
      // iteration 1: back-to-back load, inputs left asserted outside LOAD
      load_b2b();
      outs(-1, -1);
      check("wrap_wen_x", wr_en_x, 1);
      check("wrap_wa_x", wr_addr_x, 0);
      s_valid_x = 0;
      s_valid_f = 0;
      tick;
      // iteration 2: random gaps, x and f finish on the same edge, stall at k=5
      ex = 0;
      ef = 0;
      for (int c = 0; c < 2000 && ex < N - 1; c++) begin
         s_valid_x = 1'($urandom_range(0, 1));
         #1;
         check("rx_wen", wr_en_x, s_valid_x);
         check("rx_addr", wr_addr_x, ex);
         check("rx_rdy_f", s_ready_f, 1);
         check("rx_wen_f", wr_en_f, 0);
         if (s_valid_x) ex++;
         tick;
      end
      s_valid_x = 0;
      for (int c = 0; c < 2000 && ef < M - 1; c++) begin
         s_valid_f = 1'($urandom_range(0, 1));
         #1;
         check("rf_wen", wr_en_f, s_valid_f);
         check("rf_addr", wr_addr_f, ef);
         check("rf_rdy_x", s_ready_x, 1);
         check("rf_wen_x", wr_en_x, 0);
         if (s_valid_f) ef++;
         tick;
      end
      s_valid_x = 1;
      s_valid_f = 1;
      #1;
      check("sim_wen_x", wr_en_x, 1);
      check("sim_wen_f", wr_en_f, 1);
      check("sim_wa_x", wr_addr_x, N - 1);
      check("sim_wa_f", wr_addr_f, M - 1);
      tick;
      s_valid_x = 0;
      s_valid_f = 0;
      outs(5, -1);
      tick;
      // iteration 3: asynchronous reset while presenting k=40
      load_b2b();
      outs(-1, 40);
      s_valid_x = 0;
      s_valid_f = 0;
      #2;
      reset = 0;
      #1;
      check_reset_vals("arst");
      @(negedge clk);
      reset = 1;
      tick;
      // iteration 4: full run after reset
      load_b2b();
      outs(-1, -1);
      s_valid_x = 0;
      s_valid_f = 0;
      tick;
      check("end_vld", m_valid_y, 0);
      check("end_rdy_x", s_ready_x, 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
